// File: rtl/spi_slave_reg_bridge.sv
// Byte-level command decoder behind an SPI slave: CS-framed transactions become
// reads/writes of a small 8-bit register file with auto-incrementing address.
module spi_slave_reg_bridge #(
  parameter int unsigned ADDR_WIDTH  = 3,
  parameter logic [7:0]  ID_BYTE     = 8'h5C,
  parameter logic [7:0]  STATUS_BYTE = 8'hA5,
  parameter logic [7:0]  ERR_BYTE    = 8'hEE
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst,
  input  logic                           i_SPI_CS_n,
  input  logic                           i_RX_DV,
  input  logic [7:0]                     i_RX_Byte,
  output logic                           o_TX_DV,
  output logic [7:0]                     o_TX_Byte,
  output logic [8*(2**ADDR_WIDTH)-1:0]   o_Regs,
  output logic                           o_Wr_Strobe,
  output logic [ADDR_WIDTH-1:0]          o_Wr_Addr,
  output logic                           o_Busy,
  output logic [7:0]                     o_Err_Count
);

  localparam int unsigned NUM_REGS = 2**ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WRITE, READ, ERROR} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [7:0]            regs [NUM_REGS];
  logic                  cs_meta, cs_sync, cs_prev;
  logic                  cs_rise, rx_ok, cmd_legal;
  logic [ADDR_WIDTH-1:0] cmd_addr;

  // Chip select synchroniser and rising-edge detector
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      cs_meta <= 1'b1;
      cs_sync <= 1'b1;
      cs_prev <= 1'b1;
    end else begin
      cs_meta <= i_SPI_CS_n;
      cs_sync <= cs_meta;
      cs_prev <= cs_sync;
    end
  end

  assign cs_rise   = cs_sync & ~cs_prev;
  // A byte landing on the same cycle as the detected CS rise still belongs to the frame
  assign rx_ok     = i_RX_DV & (~cs_sync | cs_rise);
  assign cmd_legal = (i_RX_Byte[6:0] >> ADDR_WIDTH) == 7'd0;
  assign cmd_addr  = i_RX_Byte[ADDR_WIDTH-1:0];

  // Frame decoder, register file and TX byte generation
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state       <= IDLE;
      ptr         <= '0;
      o_TX_DV     <= 1'b0;
      o_TX_Byte   <= STATUS_BYTE;
      o_Wr_Strobe <= 1'b0;
      o_Wr_Addr   <= '0;
      o_Busy      <= 1'b0;
      o_Err_Count <= 8'h00;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == 0) ? ID_BYTE : 8'h00;
      end
    end else begin
      o_TX_DV     <= 1'b0;
      o_Wr_Strobe <= 1'b0;
      if (rx_ok) begin
        o_TX_DV <= 1'b1;
        case (state)
          IDLE: begin
            o_Busy <= 1'b1;
            if (!cmd_legal) begin
              state     <= ERROR;
              o_TX_Byte <= ERR_BYTE;
              if (o_Err_Count != 8'hFF) o_Err_Count <= o_Err_Count + 8'd1;
            end else if (i_RX_Byte[7]) begin
              state     <= WRITE;
              ptr       <= cmd_addr;
              o_TX_Byte <= STATUS_BYTE;
            end else begin
              state     <= READ;
              ptr       <= cmd_addr + 1'b1;
              o_TX_Byte <= regs[cmd_addr];
            end
          end
          WRITE: begin
            // Register 0 holds the read-only ID, so writes to it are dropped silently
            if (ptr != '0) begin
              regs[ptr]   <= i_RX_Byte;
              o_Wr_Strobe <= 1'b1;
              o_Wr_Addr   <= ptr;
            end
            ptr       <= ptr + 1'b1;
            o_TX_Byte <= i_RX_Byte;
          end
          READ: begin
            ptr       <= ptr + 1'b1;
            o_TX_Byte <= regs[ptr];
          end
          default: o_TX_Byte <= ERR_BYTE;
        endcase
      end
      if (cs_rise) begin
        state     <= IDLE;
        o_Busy    <= 1'b0;
        o_TX_DV   <= 1'b1;
        o_TX_Byte <= STATUS_BYTE;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign o_Regs[8*g +: 8] = regs[g];
  end

endmodule

// File: tb/tb_spi_slave_reg_bridge.sv
// Directed and randomized frames for spi_slave_reg_bridge, checked against a
// frame-level reference model of the register file and error counter.
module tb_spi_slave_reg_bridge;

  localparam int unsigned AW = 3;
  localparam int unsigned N  = 8;
  localparam logic [7:0] ID  = 8'h5C;
  localparam logic [7:0] ST  = 8'hA5;
  localparam logic [7:0] ER  = 8'hEE;

  typedef logic [7:0] bq_t [$];

  logic          clk = 1'b0;
  logic          rst;
  logic          cs_n;
  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic          tx_dv;
  logic [7:0]    tx_byte;
  logic [8*N-1:0] regs_flat;
  logic          wr_strobe;
  logic [AW-1:0] wr_addr;
  logic          busy;
  logic [7:0]    err_count;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_regs [N];
  int         m_err;

  spi_slave_reg_bridge #(
    .ADDR_WIDTH(AW), .ID_BYTE(ID), .STATUS_BYTE(ST), .ERR_BYTE(ER)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_SPI_CS_n(cs_n), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte),
    .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte), .o_Regs(regs_flat), .o_Wr_Strobe(wr_strobe),
    .o_Wr_Addr(wr_addr), .o_Busy(busy), .o_Err_Count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_regs[i] = 8'h00;
    m_regs[0] = ID;
    m_err = 0;
  endtask

  task automatic check_state(input string tag);
    for (int r = 0; r < N; r++) check({tag, "_reg"}, 32'(regs_flat[8*r +: 8]), 32'(m_regs[r]));
    check({tag, "_errcnt"}, 32'(err_count), 32'(m_err));
  endtask

  // Drive one CS-framed transaction; the model derives each response from the frame rules
  task automatic run_frame(input bq_t b, input bit coincident);
    logic [7:0] cmd;
    bit         legal, wr, exp_stb;
    int         base, a;
    logic [7:0] exp_tx;
    cmd   = b[0];
    legal = int'(cmd[6:0]) < N;
    wr    = cmd[7];
    base  = int'(cmd[6:0]) % N;
    cs_n  = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < b.size(); i++) begin
      exp_stb = 1'b0;
      a       = 0;
      if (!legal) begin
        exp_tx = ER;
        if (i == 0 && m_err < 255) m_err++;
      end else if (i == 0) begin
        exp_tx = wr ? ST : m_regs[base];
      end else if (wr) begin
        a      = (base + i - 1) % N;
        exp_tx = b[i];
        if (a != 0) begin
          m_regs[a] = b[i];
          exp_stb   = 1'b1;
        end
      end else begin
        exp_tx = m_regs[(base + i) % N];
      end
      if (coincident && i == b.size() - 1) begin
        cs_n = 1'b1;
        tick();
        tick();
        exp_tx = ST;
      end
      rx_dv   = 1'b1;
      rx_byte = b[i];
      tick();
      rx_dv   = 1'b0;
      rx_byte = $urandom();
      check("tx_dv", 32'(tx_dv), 32'd1);
      check("tx_byte", 32'(tx_byte), 32'(exp_tx));
      check("wr_strobe", 32'(wr_strobe), 32'(exp_stb));
      if (exp_stb) check("wr_addr", 32'(wr_addr), 32'(a));
      check("busy", 32'(busy), (coincident && i == b.size() - 1) ? 32'd0 : 32'd1);
      tick();
      check("tx_dv_gap", 32'(tx_dv), 32'd0);
      check("tx_hold", 32'(tx_byte), 32'(exp_tx));
      tick();
    end
    if (!coincident) begin
      cs_n = 1'b1;
      repeat (3) tick();
      check("end_tx_dv", 32'(tx_dv), 32'd1);
      check("end_tx_byte", 32'(tx_byte), 32'(ST));
      check("end_busy", 32'(busy), 32'd0);
    end
    tick();
    check("idle_tx_dv", 32'(tx_dv), 32'd0);
  endtask

  initial begin
    bq_t        fr;
    logic [6:0] a7;
    rst     = 1'b1;
    cs_n    = 1'b1;
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
    model_reset();
    repeat (3) tick();
    check("rst_tx_dv", 32'(tx_dv), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'(ST));
    check("rst_strobe", 32'(wr_strobe), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check_state("rst");
    rst = 1'b0;
    repeat (2) tick();

    fr = {8'h81, 8'h3C};                   run_frame(fr, 1'b0); check_state("wr1");
    fr = {8'h01, 8'h00, 8'h00};            run_frame(fr, 1'b0); check_state("rd1");
    fr = {8'h86, 8'h11, 8'h22, 8'h33};     run_frame(fr, 1'b0); check_state("burst");
    fr = {8'h87, 8'hAA, 8'hBB, 8'hCC};     run_frame(fr, 1'b0); check_state("wrap");
    fr = {8'h80, 8'hFF};                   run_frame(fr, 1'b0); check_state("wr0");
    fr = {8'h00, 8'h00};                   run_frame(fr, 1'b0); check_state("rd0");
    fr = {8'h88, 8'h12};                   run_frame(fr, 1'b0); check_state("illegal");
    fr = {8'h06, 8'h00, 8'h00, 8'h00};     run_frame(fr, 1'b0); check_state("after_err");
    fr = {8'h83, 8'h55, 8'h66};            run_frame(fr, 1'b1); check_state("coincident");

    // A byte strobe while CS is deasserted must not start a frame
    rx_dv = 1'b1; rx_byte = 8'h82; tick(); rx_dv = 1'b0;
    check("cs_high_tx_dv", 32'(tx_dv), 32'd0);
    check("cs_high_busy", 32'(busy), 32'd0);
    check("cs_high_strobe", 32'(wr_strobe), 32'd0);
    tick();
    check_state("cs_high");

    for (int f = 0; f < 40; f++) begin
      fr.delete();
      a7 = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(8, 127)) : 7'($urandom_range(0, 7));
      fr.push_back({1'($urandom_range(0, 1)), a7});
      for (int k = 0, n = $urandom_range(0, 9); k < n; k++) fr.push_back(8'($urandom()));
      run_frame(fr, $urandom_range(0, 3) == 0);
    end
    check_state("random");

    for (int f = 0; f < 260; f++) begin
      fr = {8'hF0};
      run_frame(fr, 1'b0);
    end
    check_state("saturate");
    fr = {8'h85, 8'h77};                   run_frame(fr, 1'b0); check_state("post_sat");

    // Reset in the middle of a burst write
    cs_n = 1'b0;
    repeat (3) tick();
    rx_dv = 1'b1; rx_byte = 8'h82; tick();
    rx_byte = 8'h44; tick();
    rx_dv = 1'b0;
    rst   = 1'b1;
    cs_n  = 1'b1;
    #1;
    model_reset();
    check("mid_rst_tx_dv", 32'(tx_dv), 32'd0);
    check("mid_rst_tx_byte", 32'(tx_byte), 32'(ST));
    check("mid_rst_strobe", 32'(wr_strobe), 32'd0);
    check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check_state("mid_rst");
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    fr = {8'h82, 8'h9A, 8'hBC};            run_frame(fr, 1'b0); check_state("post_rst_wr");
    fr = {8'h02, 8'h00, 8'h00};            run_frame(fr, 1'b0); check_state("post_rst_rd");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
